// File: rtl/mem_req_queue.sv
// mem_req_queue: buffers memory commands and write beats toward DRAM and registers DRAM responses
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   up_req_*  (valid/ready/rw/addr/tag) command stream from the core/cache top level
//   up_data_* (valid/ready/bits/mask)   write-beat stream from the top level
//   dn_req_*                            in-order command stream to DRAM
//   dn_data_* (+offset)                 released write beats to DRAM, tagged with beat index
//   dn_resp_*                           DRAM responses (no backpressure)
//   up_resp_*                           one-cycle registered copy of the DRAM responses
module mem_req_queue #(
    parameter int ADDR_BITS  = 28,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BITS  = 128,
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 8,
    parameter int BEATS      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   up_req_valid,
    output logic                   up_req_ready,
    input  logic                   up_req_rw,
    input  logic [ADDR_BITS-1:0]   up_req_addr,
    input  logic [TAG_BITS-1:0]    up_req_tag,
    input  logic                   up_data_valid,
    output logic                   up_data_ready,
    input  logic [DATA_BITS-1:0]   up_data_bits,
    input  logic [DATA_BITS/8-1:0] up_data_mask,
    output logic                   dn_req_valid,
    input  logic                   dn_req_ready,
    output logic                   dn_req_rw,
    output logic [ADDR_BITS-1:0]   dn_req_addr,
    output logic [TAG_BITS-1:0]    dn_req_tag,
    output logic                   dn_data_valid,
    input  logic                   dn_data_ready,
    output logic [DATA_BITS-1:0]   dn_data_bits,
    output logic [DATA_BITS/8-1:0] dn_data_mask,
    output logic [1:0]             dn_data_offset,
    input  logic                   dn_resp_valid,
    input  logic [TAG_BITS-1:0]    dn_resp_tag,
    input  logic [DATA_BITS-1:0]   dn_resp_data,
    output logic                   up_resp_valid,
    output logic [TAG_BITS-1:0]    up_resp_tag,
    output logic [DATA_BITS-1:0]   up_resp_data
);
    localparam int MW  = DATA_BITS / 8;
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int DCW = DAW + 1;
    localparam logic [DCW-1:0] BEATS_W = DCW'(BEATS);

    logic                 r_cmd_rw   [CMD_DEPTH];
    logic [ADDR_BITS-1:0] r_cmd_addr [CMD_DEPTH];
    logic [TAG_BITS-1:0]  r_cmd_tag  [CMD_DEPTH];
    logic [CAW-1:0]       r_cmd_wr, r_cmd_rd;
    logic [CCW-1:0]       r_cmd_count;

    logic [DATA_BITS-1:0] r_dat_bits [DATA_DEPTH];
    logic [MW-1:0]        r_dat_mask [DATA_DEPTH];
    logic [DAW-1:0]       r_dat_wr, r_dat_rd;
    logic [DCW-1:0]       r_dat_count;
    // beats already owned by issued write commands but not yet sent
    logic [DCW-1:0]       r_released;
    logic [1:0]           r_offset;

    logic                 r_resp_valid;
    logic [TAG_BITS-1:0]  r_resp_tag;
    logic [DATA_BITS-1:0] r_resp_data;

    logic           w_cmd_empty, w_dat_empty, w_head_rw;
    logic           w_cmd_push, w_cmd_pop, w_dat_push, w_dat_pop;
    logic [DCW-1:0] w_unclaimed;

    assign w_cmd_empty = (r_cmd_count == '0);
    assign w_dat_empty = (r_dat_count == '0);
    assign w_head_rw   = r_cmd_rw[r_cmd_rd];
    assign w_unclaimed = r_dat_count - r_released;

    assign up_req_ready  = (r_cmd_count != CCW'(CMD_DEPTH));
    assign up_data_ready = (r_dat_count != DCW'(DATA_DEPTH));

    // a write waits at the head until a full burst of unowned beats is buffered
    assign dn_req_valid = !w_cmd_empty && (!w_head_rw || w_unclaimed >= BEATS_W);
    assign dn_req_rw    = !w_cmd_empty && w_head_rw;
    assign dn_req_addr  = w_cmd_empty ? '0 : r_cmd_addr[r_cmd_rd];
    assign dn_req_tag   = w_cmd_empty ? '0 : r_cmd_tag[r_cmd_rd];

    assign dn_data_valid  = !w_dat_empty && (r_released != '0);
    assign dn_data_bits   = w_dat_empty ? '0 : r_dat_bits[r_dat_rd];
    assign dn_data_mask   = w_dat_empty ? '0 : r_dat_mask[r_dat_rd];
    assign dn_data_offset = r_offset;

    assign up_resp_valid = r_resp_valid;
    assign up_resp_tag   = r_resp_tag;
    assign up_resp_data  = r_resp_data;

    assign w_cmd_push = up_req_valid && up_req_ready;
    assign w_cmd_pop  = dn_req_valid && dn_req_ready;
    assign w_dat_push = up_data_valid && up_data_ready;
    assign w_dat_pop  = dn_data_valid && dn_data_ready;

    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_rw[r_cmd_wr]   <= up_req_rw;
            r_cmd_addr[r_cmd_wr] <= up_req_addr;
            r_cmd_tag[r_cmd_wr]  <= up_req_tag;
        end
        if (w_dat_push) begin
            r_dat_bits[r_dat_wr] <= up_data_bits;
            r_dat_mask[r_dat_wr] <= up_data_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_wr     <= '0;
            r_cmd_rd     <= '0;
            r_cmd_count  <= '0;
            r_dat_wr     <= '0;
            r_dat_rd     <= '0;
            r_dat_count  <= '0;
            r_released   <= '0;
            r_offset     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + 1'b1;
            if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + 1'b1;
            if (w_dat_push) r_dat_wr <= r_dat_wr + 1'b1;
            if (w_dat_pop)  r_dat_rd <= r_dat_rd + 1'b1;
            r_cmd_count  <= r_cmd_count + CCW'(w_cmd_push) - CCW'(w_cmd_pop);
            r_dat_count  <= r_dat_count + DCW'(w_dat_push) - DCW'(w_dat_pop);
            r_released   <= r_released + ((w_cmd_pop && w_head_rw) ? BEATS_W : '0) - DCW'(w_dat_pop);
            r_offset     <= r_offset + 2'(w_dat_pop);
            r_resp_valid <= dn_resp_valid;
            if (dn_resp_valid) begin
                r_resp_tag  <= dn_resp_tag;
                r_resp_data <= dn_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_mem_req_queue;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         up_req_valid = 1'b0, up_req_ready, up_req_rw = 1'b0;
    logic [27:0]  up_req_addr = '0;
    logic [4:0]   up_req_tag = '0;
    logic         up_data_valid = 1'b0, up_data_ready;
    logic [127:0] up_data_bits = '0;
    logic [15:0]  up_data_mask = '0;
    logic         dn_req_valid, dn_req_ready = 1'b0, dn_req_rw;
    logic [27:0]  dn_req_addr;
    logic [4:0]   dn_req_tag;
    logic         dn_data_valid, dn_data_ready = 1'b0;
    logic [127:0] dn_data_bits;
    logic [15:0]  dn_data_mask;
    logic [1:0]   dn_data_offset;
    logic         dn_resp_valid = 1'b0;
    logic [4:0]   dn_resp_tag = '0;
    logic [127:0] dn_resp_data = '0;
    logic         up_resp_valid;
    logic [4:0]   up_resp_tag;
    logic [127:0] up_resp_data;

    int checks = 0;
    int errors = 0;

    typedef struct { logic rw; logic [27:0] addr; logic [4:0] tag; } cmd_t;
    typedef struct { logic [127:0] bits; logic [15:0] mask; } beat_t;

    mem_req_queue dut (
        .clk(clk), .reset(reset),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_rw(up_req_rw),
        .up_req_addr(up_req_addr), .up_req_tag(up_req_tag),
        .up_data_valid(up_data_valid), .up_data_ready(up_data_ready),
        .up_data_bits(up_data_bits), .up_data_mask(up_data_mask),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_rw(dn_req_rw),
        .dn_req_addr(dn_req_addr), .dn_req_tag(dn_req_tag),
        .dn_data_valid(dn_data_valid), .dn_data_ready(dn_data_ready),
        .dn_data_bits(dn_data_bits), .dn_data_mask(dn_data_mask), .dn_data_offset(dn_data_offset),
        .dn_resp_valid(dn_resp_valid), .dn_resp_tag(dn_resp_tag), .dn_resp_data(dn_resp_data),
        .up_resp_valid(up_resp_valid), .up_resp_tag(up_resp_tag), .up_resp_data(up_resp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        up_req_valid  = 1'b0;
        up_data_valid = 1'b0;
        dn_req_ready  = 1'b0;
        dn_data_ready = 1'b0;
        dn_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({up_req_ready, up_data_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b want 11", {up_req_ready, up_data_ready});
        end
        checks++;
        if ({dn_req_valid, dn_data_valid, up_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: got %b want 000", {dn_req_valid, dn_data_valid, up_resp_valid});
        end
        checks++;
        if (dn_data_offset !== 2'd0) begin
            errors++;
            $display("FAIL reset_offset: got %0d want 0", dn_data_offset);
        end
        checks++;
        if ({dn_req_addr, dn_req_tag, dn_data_bits, dn_data_mask, up_resp_tag, up_resp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_zero: tag %h addr %h resp_tag %h not all zero", dn_req_tag, dn_req_addr, up_resp_tag);
        end
    endtask

    task automatic test_read();
        dn_req_ready = 1'b1;
        up_req_valid = 1'b1;
        up_req_rw    = 1'b0;
        up_req_addr  = 28'h0000100;
        up_req_tag   = 5'd3;
        checks++;
        if (dn_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_no_bypass: got %b want 0", dn_req_valid);
        end
        tick();
        up_req_valid = 1'b0;
        checks++;
        if ({dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag} !== {1'b1, 1'b0, 28'h0000100, 5'd3}) begin
            errors++;
            $display("FAIL read_issue: got v=%b rw=%b addr=%h tag=%0d want v=1 rw=0 addr=0000100 tag=3",
                     dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag);
        end
        tick();
        checks++;
        if ({dn_req_valid, up_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_empty_after: got valid=%b ready=%b want 0 1", dn_req_valid, up_req_ready);
        end
        dn_req_ready = 1'b0;
    endtask

    task automatic test_write_gating();
        logic [127:0] pb [4];
        logic [15:0]  pm [4];
        for (int i = 0; i < 4; i++) begin
            pb[i] = {4{32'hABCD0000 + 32'(i)}};
            pm[i] = 16'h1111 << i;
        end
        dn_req_ready  = 1'b1;
        dn_data_ready = 1'b0;
        up_req_valid  = 1'b1;
        up_req_rw     = 1'b1;
        up_req_addr   = 28'h0000200;
        up_req_tag    = 5'd1;
        tick();
        up_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dn_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_gated_beats%0d: dn_req_valid got %b want 0", i, dn_req_valid);
            end
            up_data_valid = 1'b1;
            up_data_bits  = pb[i];
            up_data_mask  = pm[i];
            tick();
        end
        up_data_valid = 1'b0;
        checks++;
        if ({dn_req_valid, dn_req_rw, dn_req_tag, dn_data_valid} !== {1'b1, 1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL write_ready_to_issue: got v=%b rw=%b tag=%0d dv=%b want 1 1 1 0",
                     dn_req_valid, dn_req_rw, dn_req_tag, dn_data_valid);
        end
        tick();
        dn_req_ready  = 1'b0;
        dn_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dn_data_valid, dn_data_offset, dn_data_bits, dn_data_mask} !== {1'b1, 2'(i), pb[i], pm[i]}) begin
                errors++;
                $display("FAIL write_beat%0d: got v=%b off=%0d bits=%h mask=%h want v=1 off=%0d bits=%h mask=%h",
                         i, dn_data_valid, dn_data_offset, dn_data_bits, dn_data_mask, i, pb[i], pm[i]);
            end
            tick();
        end
        dn_data_ready = 1'b0;
        checks++;
        if ({dn_data_valid, dn_data_offset, dn_req_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL write_drained: got dv=%b off=%0d rv=%b want 0 0 0", dn_data_valid, dn_data_offset, dn_req_valid);
        end
    endtask

    task automatic test_full();
        dn_req_ready = 1'b0;
        up_req_rw    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_req_valid = 1'b1;
            up_req_addr  = 28'(i * 16);
            up_req_tag   = 5'(i);
            tick();
        end
        checks++;
        if (up_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", up_req_ready);
        end
        up_req_tag = 5'd9;
        tick();
        up_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        checks++;
        if ({up_req_ready, dn_req_tag} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL full_after_pop: got ready=%b tag=%0d want 1 1", up_req_ready, dn_req_tag);
        end
        dn_req_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if ({dn_req_valid, dn_req_tag} !== {1'b1, 5'(i)}) begin
                errors++;
                $display("FAIL full_order%0d: got v=%b tag=%0d want v=1 tag=%0d", i, dn_req_valid, dn_req_tag, i);
            end
            tick();
        end
        checks++;
        if (dn_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_fifth_dropped: dn_req_valid got %b tag %0d want 0", dn_req_valid, dn_req_tag);
        end
        dn_req_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        dn_req_ready  = 1'b0;
        dn_data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_data_valid = 1'b1;
            up_data_bits  = {4{$urandom}};
            up_data_mask  = 16'hFFFF;
            tick();
        end
        up_data_valid = 1'b0;
        up_req_valid  = 1'b1;
        up_req_rw     = 1'b1;
        up_req_tag    = 5'd2;
        tick();
        up_req_rw  = 1'b0;
        up_req_tag = 5'd4;
        tick();
        up_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        checks++;
        if ({dn_req_valid, dn_req_rw, dn_req_tag} !== {1'b1, 1'b1, 5'd2}) begin
            errors++;
            $display("FAIL b2b_write_first: got v=%b rw=%b tag=%0d want 1 1 2", dn_req_valid, dn_req_rw, dn_req_tag);
        end
        tick();
        checks++;
        if ({dn_req_valid, dn_req_rw, dn_req_tag, dn_data_valid} !== {1'b1, 1'b0, 5'd4, 1'b1}) begin
            errors++;
            $display("FAIL b2b_read_next: got v=%b rw=%b tag=%0d dv=%b want 1 0 4 1",
                     dn_req_valid, dn_req_rw, dn_req_tag, dn_data_valid);
        end
        tick();
        tick();
        checks++;
        if ({dn_req_valid, dn_data_valid} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_data_held: got rv=%b dv=%b want 0 1", dn_req_valid, dn_data_valid);
        end
        dn_req_ready  = 1'b0;
        dn_data_ready = 1'b1;
        repeat (4) tick();
        dn_data_ready = 1'b0;
        checks++;
        if ({dn_data_valid, up_data_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_drained: got dv=%b ready=%b want 0 1", dn_data_valid, up_data_ready);
        end
    endtask

    task automatic test_resp_and_reset();
        dn_resp_valid = 1'b1;
        dn_resp_tag   = 5'd7;
        dn_resp_data  = {4{32'hDEADBEEF}};
        tick();
        dn_resp_valid = 1'b0;
        dn_resp_tag   = 5'd12;
        checks++;
        if ({up_resp_valid, up_resp_tag, up_resp_data} !== {1'b1, 5'd7, {4{32'hDEADBEEF}}}) begin
            errors++;
            $display("FAIL resp_pulse: got v=%b tag=%0d data=%h want 1 7 deadbeef*4", up_resp_valid, up_resp_tag, up_resp_data);
        end
        tick();
        checks++;
        if ({up_resp_valid, up_resp_tag} !== {1'b0, 5'd7}) begin
            errors++;
            $display("FAIL resp_hold: got v=%b tag=%0d want 0 7", up_resp_valid, up_resp_tag);
        end
        dn_req_ready  = 1'b1;
        up_req_valid  = 1'b1;
        up_req_rw     = 1'b1;
        up_req_tag    = 5'd6;
        up_data_valid = 1'b1;
        up_data_mask  = 16'h00FF;
        tick();
        up_req_valid = 1'b0;
        repeat (3) tick();
        up_data_valid = 1'b0;
        tick();
        dn_data_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({dn_data_valid, dn_data_offset} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL midwrite_offset: got dv=%b off=%0d want 1 2", dn_data_valid, dn_data_offset);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({dn_data_valid, dn_data_offset, dn_req_valid, up_resp_valid, up_req_ready, up_data_ready} !== 7'b0000011) begin
            errors++;
            $display("FAIL reset_midwrite: got dv=%b off=%0d rv=%b resp=%b rr=%b dr=%b want 0 0 0 0 1 1",
                     dn_data_valid, dn_data_offset, dn_req_valid, up_resp_valid, up_req_ready, up_data_ready);
        end
        up_data_valid = 1'b1;
        repeat (4) tick();
        up_data_valid = 1'b0;
        checks++;
        if ({dn_data_valid, dn_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_stale_release: got dv=%b rv=%b want 0 0", dn_data_valid, dn_req_valid);
        end
        do_reset();
    endtask

    task automatic test_random(input int n);
        cmd_t  cq[$];
        beat_t dq[$];
        cmd_t  hc;
        beat_t hb;
        int    rel = 0, off = 0;
        logic  pv = 1'b0, ev_req, ev_dat, rw0;
        logic [4:0]   pt = '0;
        logic [127:0] pd = '0;
        do_reset();
        for (int i = 0; i < n && errors < 40; i++) begin
            up_req_valid  = ($urandom_range(0, 1) == 1);
            up_req_rw     = ($urandom_range(0, 3) == 0);
            up_req_addr   = 28'($urandom);
            up_req_tag    = 5'($urandom);
            up_data_valid = ($urandom_range(0, 1) == 1);
            up_data_bits  = {$urandom, $urandom, $urandom, $urandom};
            up_data_mask  = 16'($urandom);
            dn_req_ready  = ($urandom_range(0, 3) != 0);
            dn_data_ready = ($urandom_range(0, 3) != 0);
            dn_resp_valid = ($urandom_range(0, 1) == 1);
            dn_resp_tag   = 5'($urandom);
            dn_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            hc = '{1'b0, 28'd0, 5'd0};
            hb = '{128'd0, 16'd0};
            if (cq.size() != 0) hc = cq[0];
            if (dq.size() != 0) hb = dq[0];
            ev_req = cq.size() != 0 && (!hc.rw || dq.size() - rel >= 4);
            ev_dat = dq.size() != 0 && rel != 0;
            checks++;
            if ({up_req_ready, up_data_ready} !== {cq.size() != 4, dq.size() != 8}) begin
                errors++;
                $display("FAIL rand_ready cyc%0d: got %b%b want %b%b", i, up_req_ready, up_data_ready, cq.size() != 4, dq.size() != 8);
            end
            checks++;
            if ({dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag} !== {ev_req, hc.rw, hc.addr, hc.tag}) begin
                errors++;
                $display("FAIL rand_req cyc%0d: got v=%b rw=%b addr=%h tag=%0d want v=%b rw=%b addr=%h tag=%0d",
                         i, dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag, ev_req, hc.rw, hc.addr, hc.tag);
            end
            checks++;
            if ({dn_data_valid, dn_data_offset, dn_data_bits, dn_data_mask} !== {ev_dat, 2'(off), hb.bits, hb.mask}) begin
                errors++;
                $display("FAIL rand_data cyc%0d: got v=%b off=%0d bits=%h mask=%h want v=%b off=%0d bits=%h mask=%h",
                         i, dn_data_valid, dn_data_offset, dn_data_bits, dn_data_mask, ev_dat, off, hb.bits, hb.mask);
            end
            checks++;
            if ({up_resp_valid, up_resp_tag, up_resp_data} !== {pv, pt, pd}) begin
                errors++;
                $display("FAIL rand_resp cyc%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                         i, up_resp_valid, up_resp_tag, up_resp_data, pv, pt, pd);
            end
            @(posedge clk);
            if (ev_req && dn_req_ready) begin
                rw0 = hc.rw;
                void'(cq.pop_front());
                if (rw0) rel += 4;
            end
            if (ev_dat && dn_data_ready) begin
                void'(dq.pop_front());
                rel--;
                off = (off + 1) % 4;
            end
            if (up_req_valid && cq.size() + ((ev_req && dn_req_ready) ? 1 : 0) != 4)
                cq.push_back('{up_req_rw, up_req_addr, up_req_tag});
            if (up_data_valid && dq.size() + ((ev_dat && dn_data_ready) ? 1 : 0) != 8)
                dq.push_back('{up_data_bits, up_data_mask});
            pv = dn_resp_valid;
            if (dn_resp_valid) begin
                pt = dn_resp_tag;
                pd = dn_resp_data;
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_gating();
        test_full();
        test_back_to_back();
        test_resp_and_reset();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Request/response buffering stage directly downstream of the core-plus-cache top level.
- Accepts the top level's memory command stream and write-data stream and queues each in its own FIFO. Presents both to the external DRAM port in order, and registers DRAM responses on their way back.
- Guarantees a write command is never issued downstream until all of its data beats are buffered. Data beats are released only after their command has issued, each tagged with a beat offset.

Parameters:
- ADDR_BITS, 28, command address width (matches MEM_ADDR_BITS).
- TAG_BITS, 5, request/response tag width (matches MEM_TAG_BITS).
- DATA_BITS, 128, data beat width (matches MEM_DATA_BITS); mask width is DATA_BITS/8.
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2.
- DATA_DEPTH, 8, write-data FIFO entries; power of two, ≥BEATS.
- BEATS, 4, data beats per write command; fixed at 4 (2-bit offset).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- up_req_valid  in  1  command valid from top level.
- up_req_ready  out  1  command FIFO not full.
- up_req_rw  in  1  1 = write, 0 = read.
- up_req_addr  in  ADDR_BITS  command address.
- up_req_tag  in  TAG_BITS  command tag.
- up_data_valid  in  1  write beat valid.
- up_data_ready  out  1  data FIFO not full.
- up_data_bits  in  DATA_BITS  write beat.
- up_data_mask  in  DATA_BITS/8  byte mask.
- dn_req_valid  out  1  command to DRAM valid.
- dn_req_ready  in  1  DRAM accepts command.
- dn_req_rw  out  1  queued rw.
- dn_req_addr  out  ADDR_BITS  queued address.
- dn_req_tag  out  TAG_BITS  queued tag.
- dn_data_valid  out  1  write beat to DRAM valid.
- dn_data_ready  in  1  DRAM accepts beat.
- dn_data_bits  out  DATA_BITS  beat.
- dn_data_mask  out  DATA_BITS/8  mask.
- dn_data_offset  out  2  beat index within current write (0..3).
- dn_resp_valid  in  1  DRAM response valid (no backpressure).
- dn_resp_tag  in  TAG_BITS  response tag.
- dn_resp_data  in  DATA_BITS  response data.
- up_resp_valid  out  1  registered response valid.
- up_resp_tag  out  TAG_BITS  registered tag.
- up_resp_data  out  DATA_BITS  registered data.

Behaviour:

Reset
- On reset high at a clk edge: both FIFOs empty, all counters 0, dn_data_offset=0.
- up_req_ready=1, up_data_ready=1, dn_req_valid=0, dn_data_valid=0, up_resp_valid=0; tag/data outputs 0.
- Reset mid-transfer discards all queued commands and beats, including partially released writes.

Handshakes
- A transfer occurs on the edge where valid&ready=1.
- up_*_ready derive only from registered occupancy, never from downstream ready.
- No bypass: an entry pushed at edge N is visible downstream no earlier than cycle N+1.

Command FIFO
- up_req_ready = (cmd_count != CMD_DEPTH).
- The head drives dn_req_rw/addr/tag whenever the FIFO is non-empty.
- dn_req_valid = !cmd_empty && (head_rw==0 || unclaimed >= BEATS).
- Strict order: a read behind a blocked write waits.

Data FIFO
- up_data_ready = (data_count != DATA_DEPTH).
- Stores {bits, mask}.
- unclaimed = data_count − released, where released counts beats belonging to already-issued writes.
- On a write-command pop: released += BEATS.
- On a beat pop: released −= 1, and dn_data_offset increments, wrapping 3→0.
- dn_data_valid = !data_empty && released != 0.
- Command pop and beat pop in the same cycle: released += BEATS−1.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo depth.

Response path
- One-cycle register: up_resp_valid <= dn_resp_valid; tag and data load only when dn_resp_valid=1, otherwise hold.

Counter widths
- cmd_count: $clog2(CMD_DEPTH)+1 bits.
- data_count and released: $clog2(DATA_DEPTH)+1 bits; released never exceeds data_count.

Test Plan:
- Reset, then idle → up_req_ready=1, up_data_ready=1, dn_req_valid=0, dn_data_valid=0, up_resp_valid=0.
- Read cmd addr=0x0000100 tag=3, dn_req_ready=1 → dn_req_valid=1 one cycle later with addr 0x0000100, tag 3; FIFO then empty.
- Write cmd tag=1, then beats A,B,C delivered over 3 cycles → dn_req_valid stays 0. 4th beat D → dn_req_valid=1. After the command pops, beats issue with offsets 0,1,2,3 in order A..D, masks intact.
- Push 4 commands with dn_req_ready=0 → up_req_ready=0 after the 4th. A 5th valid is not accepted. One pop → ready=1 next cycle.
- Write with 4 beats queued, followed by a read: hold dn_data_ready=0 → read issues after the write command, and dn_data_valid stays 1 until the beats drain.
- dn_resp_valid pulse tag=7, data=0xDEAD...; then assert reset mid-write after 2 of 4 beats have issued → up_resp_valid pulses one cycle later with tag 7. After reset, all FIFOs are empty and offset=0.
